// File: rtl/mem_responder_pkg.sv
// Shared encodings and lane-steering helpers for mem_responder.
// Optional feature macro: MISALIGN_TRAP_EN (see mem_responder.sv).
package mem_responder_pkg;

  typedef enum logic [1:0] {
    SIZE_B   = 2'b00,
    SIZE_H   = 2'b01,
    SIZE_W   = 2'b10,
    SIZE_RSV = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    WAIT   = 2'b10,
    RESP   = 2'b11
  } state_e;

  // Force-align the byte offset to the access size (half drops bit 0, word drops both).
  function automatic logic [1:0] align_off(size_e size, logic [1:0] off);
    case (size)
      SIZE_H:  return {off[1], 1'b0};
      SIZE_W:  return 2'b00;
      default: return off;
    endcase
  endfunction

  // Byte-lane write enables for an aligned offset.
  function automatic logic [3:0] lane_be(size_e size, logic [1:0] off);
    case (size)
      SIZE_B:  return 4'b0001 << off;
      SIZE_H:  return off[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate right-aligned store data onto every lane it could target.
  function automatic logic [31:0] store_lanes(size_e size, logic [31:0] data);
    case (size)
      SIZE_B:  return {4{data[7:0]}};
      SIZE_H:  return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  // Shift the selected lanes down to bit 0 and zero-extend; never sign-extends.
  function automatic logic [31:0] load_steer(size_e size, logic [1:0] off, logic [31:0] word);
    logic [31:0] shifted;
    shifted = word >> {off, 3'b000};
    case (size)
      SIZE_B:  return {24'h0, shifted[7:0]};
      SIZE_H:  return {16'h0, shifted[15:0]};
      SIZE_W:  return word;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response channel between the load/store initiator and mem_responder.
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_responder_mem_array.sv
// DEPTH_WORDS x 32 storage with byte-lane write enables and a registered read port.
module mem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          CLK100MHZ,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_data,
  input  logic          wr_en,
  input  logic [3:0]    wr_be,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_data
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane write and synchronous read of the word being accessed.
  // NOTE: storage has no reset on purpose; contents survive rst_n and map cleanly onto RAM.
  always_ff @(posedge CLK100MHZ) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/mem_responder.sv
// Data-memory responder: one outstanding load/store, configurable wait states,
// error response for out-of-range, reserved-size and (optionally) misaligned accesses.
// Optional feature macro: MISALIGN_TRAP_EN -- when defined, misaligned half/word
// accesses are rejected; otherwise they are force-aligned and complete normally.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic            CLK100MHZ,
  input  logic            rst_n,
  mem_responder_if.slave  bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  state_e        state, state_nx;
  logic          we_q;
  size_e         size_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [CW-1:0] wait_cnt;
  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic [31:0]   rsp_rdata_q;

  logic          accept;
  logic [1:0]    off;
  logic          out_of_range;
  logic          bad_size;
  logic          misaligned;
  logic          acc_err;
  logic [31:0]   rd_data;

  assign accept = (state == IDLE) && bus.req_valid;
  assign off    = align_off(size_q, addr_q[1:0]);

  assign out_of_range = (addr_q[31:2] >= 30'(DEPTH_WORDS));
  assign bad_size     = (size_q == SIZE_RSV);
`ifdef MISALIGN_TRAP_EN
  assign misaligned   = ((size_q == SIZE_H) && addr_q[0]) ||
                        ((size_q == SIZE_W) && (addr_q[1:0] != 2'b00));
`else
  assign misaligned   = 1'b0;
`endif
  assign acc_err = out_of_range | bad_size | misaligned;

  // Read is launched on the accept edge so the word is ready during ACCESS;
  // the write commits at the edge that leaves ACCESS and never on an error.
  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_mem (
    .CLK100MHZ (CLK100MHZ),
    .rd_en     (accept),
    .rd_idx    (bus.req_addr[AW+1:2]),
    .rd_data   (rd_data),
    .wr_en     ((state == ACCESS) && we_q && !acc_err),
    .wr_be     (lane_be(size_q, off)),
    .wr_idx    (addr_q[AW+1:2]),
    .wr_data   (store_lanes(size_q, wdata_q))
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  // NOTE: the default at the top keeps every path assigned, so no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.req_valid) state_nx = ACCESS;
      ACCESS: begin
        if (WAIT_CYCLES > 0) state_nx = WAIT;
        else                 state_nx = RESP;
      end
      WAIT:    if (wait_cnt == CW'(1)) state_nx = RESP;
      RESP:    if (bus.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request capture, wait counter and registered response.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      size_q      <= SIZE_B;
      addr_q      <= '0;
      wdata_q     <= '0;
      wait_cnt    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= bus.req_we;
        size_q  <= size_e'(bus.req_size);
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      unique case (state)
        ACCESS: begin
          wait_cnt    <= CW'(WAIT_CYCLES);
          rsp_err_q   <= acc_err;
          rsp_rdata_q <= (acc_err || we_q) ? 32'h0 : load_steer(size_q, off, rd_data);
        end
        WAIT:    wait_cnt <= wait_cnt - 1'b1;
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
          end
        end
        default: ;
      endcase
      rsp_valid_q <= (state_nx == RESP);
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: table of load/store vectors fed through a
// scoreboard, plus hand-written backpressure and reset-mid-access sequences.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int WAIT = 1;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic CLK100MHZ;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  vec_t vecs[$];
  exp_t sb[$];

  mem_responder_if bus();

  mem_responder #(
    .DEPTH_WORDS (1024),
    .WAIT_CYCLES (WAIT)
  ) dut (
    .CLK100MHZ (CLK100MHZ),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  initial CLK100MHZ = 1'b0;
  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting on DUT", name);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  function automatic void add(logic we, logic [1:0] size, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] rdata, logic err);
    vecs.push_back('{we, size, addr, wdata, rdata, err});
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic we, input logic [1:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit hold_valid);
    int n = 0;
    bus.req_we    = we;
    bus.req_size  = size;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    while (!bus.req_ready) begin
      @(negedge CLK100MHZ);
      n++;
      if (n > 50) timeout("accept");
    end
    @(posedge CLK100MHZ);
    @(negedge CLK100MHZ);
    if (!hold_valid) bus.req_valid = 1'b0;
  endtask

  // Counts rising edges after the accept edge until rsp_valid is seen.
  task automatic wait_rsp(output int edges);
    edges = 0;
    while (!bus.rsp_valid) begin
      @(posedge CLK100MHZ);
      edges++;
      @(negedge CLK100MHZ);
      if (edges > 50) timeout("rsp_valid");
    end
  endtask

  task automatic finish_rsp(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: response with empty scoreboard", name);
    end else begin
      e = sb.pop_front();
      check({name, " rdata"}, bus.rsp_rdata, e.rdata);
      check({name, " err"}, 32'(bus.rsp_err), 32'(e.err));
    end
    bus.rsp_ready = 1'b1;
    @(posedge CLK100MHZ);
    @(negedge CLK100MHZ);
    bus.rsp_ready = 1'b0;
    check({name, " valid cleared"}, 32'(bus.rsp_valid), 32'd0);
    check({name, " ready after"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic transact(input vec_t v, input bit early_ready, input string name);
    int edges;
    sb.push_back('{v.rdata, v.err});
    bus.rsp_ready = early_ready;
    send(v.we, v.size, v.addr, v.wdata, 1'b0);
    wait_rsp(edges);
    check({name, " latency"}, 32'(edges), 32'(1 + WAIT));
    finish_rsp(name);
  endtask

  initial begin
    int          edges;
    logic [31:0] w10;

    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;

    add(1, SIZE_W, 32'h0000, 32'h01020304, 32'h0, 0);
    add(1, SIZE_W, 32'h0010, 32'hDEADBEEF, 32'h0, 0);
    add(0, SIZE_W, 32'h0010, 32'h0, 32'hDEADBEEF, 0);
    add(1, SIZE_B, 32'h0013, 32'h123456A5, 32'h0, 0);
    add(0, SIZE_W, 32'h0010, 32'h0, 32'hA5ADBEEF, 0);
    add(0, SIZE_B, 32'h0013, 32'h0, 32'h000000A5, 0);
    add(0, SIZE_H, 32'h0012, 32'h0, 32'h0000A5AD, 0);
    add(0, SIZE_B, 32'h0011, 32'h0, 32'h000000BE, 0);
    add(0, SIZE_H, 32'h0010, 32'h0, 32'h0000BEEF, 0);
    add(1, SIZE_W, 32'h0014, 32'h55667788, 32'h0, 0);
    add(1, SIZE_H, 32'h0016, 32'h99991234, 32'h0, 0);
    add(0, SIZE_W, 32'h0014, 32'h0, 32'h12347788, 0);
    add(1, SIZE_B, 32'h0015, 32'h000000CC, 32'h0, 0);
    add(0, SIZE_W, 32'h0014, 32'h0, 32'h1234CC88, 0);
    add(1, SIZE_W, 32'h0FFC, 32'hCAFEF00D, 32'h0, 0);
    add(1, SIZE_W, 32'h1000, 32'hFFFFFFFF, 32'h0, 1);
    add(0, SIZE_W, 32'h0FFC, 32'h0, 32'hCAFEF00D, 0);
    add(0, SIZE_W, 32'h0000, 32'h0, 32'h01020304, 0);
    add(0, SIZE_W, 32'h1000, 32'h0, 32'h0, 1);
    add(0, SIZE_B, 32'h0FFF, 32'h0, 32'h000000CA, 0);
    add(1, SIZE_B, 32'h1003, 32'h000000EE, 32'h0, 1);
    add(0, SIZE_RSV, 32'h0010, 32'h0, 32'h0, 1);
    add(1, SIZE_RSV, 32'h0010, 32'hFFFFFFFF, 32'h0, 1);
    add(0, SIZE_W, 32'h0010, 32'h0, 32'hA5ADBEEF, 0);
`ifdef MISALIGN_TRAP_EN
    add(0, SIZE_H, 32'h0013, 32'h0, 32'h0, 1);
    add(1, SIZE_W, 32'h0011, 32'h11223344, 32'h0, 1);
    add(0, SIZE_W, 32'h0010, 32'h0, 32'hA5ADBEEF, 0);
    add(0, SIZE_W, 32'h0002, 32'h0, 32'h0, 1);
    w10 = 32'hA5ADBEEF;
`else
    add(0, SIZE_H, 32'h0013, 32'h0, 32'h0000A5AD, 0);
    add(1, SIZE_W, 32'h0011, 32'h11223344, 32'h0, 0);
    add(0, SIZE_W, 32'h0010, 32'h0, 32'h11223344, 0);
    add(0, SIZE_W, 32'h0002, 32'h0, 32'h01020304, 0);
    w10 = 32'h11223344;
`endif

    // Reset state.
    repeat (3) @(negedge CLK100MHZ);
    rst_n = 1'b1;
    @(negedge CLK100MHZ);
    check("reset req_ready", 32'(bus.req_ready), 32'd1);
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset rsp_err", 32'(bus.rsp_err), 32'd0);
    check("reset rsp_rdata", bus.rsp_rdata, 32'd0);

    // Vector table; odd entries hold rsp_ready high before the response arrives.
    for (int i = 0; i < vecs.size(); i++) begin
      transact(vecs[i], bit'(i % 2), $sformatf("v%0d", i));
    end

    // Backpressure: response held 5 cycles while a second request waits.
    sb.push_back('{32'hCAFEF00D, 1'b0});
    sb.push_back('{32'h01020304, 1'b0});
    bus.rsp_ready = 1'b0;
    send(1'b0, SIZE_W, 32'h0FFC, 32'h0, 1'b1);
    bus.req_addr = 32'h0000;
    wait_rsp(edges);
    check("bp1 latency", 32'(edges), 32'(1 + WAIT));
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK100MHZ);
      @(negedge CLK100MHZ);
      check($sformatf("bp hold%0d valid", i), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("bp hold%0d rdata", i), bus.rsp_rdata, 32'hCAFEF00D);
      check($sformatf("bp hold%0d req_ready", i), 32'(bus.req_ready), 32'd0);
    end
    finish_rsp("bp1");
    @(posedge CLK100MHZ);
    @(negedge CLK100MHZ);
    bus.req_valid = 1'b0;
    wait_rsp(edges);
    check("bp2 latency", 32'(edges), 32'(1 + WAIT));
    finish_rsp("bp2");

    // Committed store, then a store discarded by reset while in ACCESS.
    transact('{1'b1, SIZE_W, 32'h20, 32'h0BADF00D, 32'h0, 1'b0}, 1'b0, "pre-rst store");
    send(1'b1, SIZE_W, 32'h20, 32'hFFFFFFFF, 1'b0);
    rst_n = 1'b0;
    @(negedge CLK100MHZ);
    check("rst access valid", 32'(bus.rsp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge CLK100MHZ);
    check("rst access ready", 32'(bus.req_ready), 32'd1);
    transact('{1'b0, SIZE_W, 32'h20, 32'h0, 32'h0BADF00D, 1'b0}, 1'b0, "discarded store");

    // Reset while the load sits in WAIT.
    send(1'b0, SIZE_W, 32'h10, 32'h0, 1'b0);
    @(posedge CLK100MHZ);
    @(negedge CLK100MHZ);
    rst_n = 1'b0;
    @(negedge CLK100MHZ);
    rst_n = 1'b1;
    @(negedge CLK100MHZ);
    check("rst wait valid", 32'(bus.rsp_valid), 32'd0);
    check("rst wait ready", 32'(bus.req_ready), 32'd1);
    check("rst wait rdata", bus.rsp_rdata, 32'd0);
    transact('{1'b0, SIZE_W, 32'h10, 32'h0, w10, 1'b0}, 1'b0, "post-rst load");

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
